// File: rtl/bsg_swap_halfword_pack.sv
// Packs 16-bit halfwords into words for the halfword swap stage, tagging each word with its first halfword's odd flag.
// Optional BSG_SWAP_HALFWORD_PACK_FLUSH_EN: a lone last_i beat emits a zero-padded word.
module bsg_swap_halfword_pack #(
    parameter int width_p = 32
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    input  logic [width_p/2-1:0] data_i,
    input  logic                 odd_i,
    input  logic                 last_i,
    input  logic                 v_i,
    output logic                 ready_o,
    output logic [width_p-1:0]   data_o,
    output logic                 swap_o,
    output logic                 v_o,
    input  logic                 yumi_i
);
    localparam int half_lp = width_p / 2;

    typedef enum logic {LO_EMPTY = 1'b0, LO_HELD = 1'b1} state_e;

    state_e               state_r, state_n;
    logic [half_lp-1:0]   lo_r;
    logic                 odd_r;
    logic [width_p-1:0]   out_r;
    logic                 out_swap_r;
    logic                 out_v_r;

    logic                 accept;
    logic                 lo_load;
    logic                 word_load;
    logic [width_p-1:0]   word_data;
    logic                 word_swap;

    // A completing word always finds room: either the register is empty or it drains this cycle.
    assign ready_o = ~out_v_r | yumi_i;
    assign accept  = v_i & ready_o;

`ifndef BSG_SWAP_HALFWORD_PACK_FLUSH_EN
    logic unused_last;
    assign unused_last = last_i;
`endif

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) state_r <= LO_EMPTY;
        else         state_r <= state_n;
    end

    always_comb begin
        state_n   = state_r;
        lo_load   = 1'b0;
        word_load = 1'b0;
        word_data = '0;
        word_swap = 1'b0;
        case (state_r)
            LO_EMPTY: begin
                if (accept) begin
`ifdef BSG_SWAP_HALFWORD_PACK_FLUSH_EN
                    if (last_i) begin
                        word_load = 1'b1;
                        word_data = {{half_lp{1'b0}}, data_i};
                        word_swap = odd_i;
                    end else begin
                        lo_load = 1'b1;
                        state_n = LO_HELD;
                    end
`else
                    lo_load = 1'b1;
                    state_n = LO_HELD;
`endif
                end
            end
            LO_HELD: begin
                if (accept) begin
                    word_load = 1'b1;
                    word_data = {data_i, lo_r};
                    word_swap = odd_r;
                    state_n   = LO_EMPTY;
                end
            end
            default: state_n = LO_EMPTY;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            lo_r  <= '0;
            odd_r <= 1'b0;
        end else if (lo_load) begin
            lo_r  <= data_i;
            odd_r <= odd_i;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            out_r      <= '0;
            out_swap_r <= 1'b0;
            out_v_r    <= 1'b0;
        end else if (word_load) begin
            out_r      <= word_data;
            out_swap_r <= word_swap;
            out_v_r    <= 1'b1;
        end else if (yumi_i) begin
            out_v_r    <= 1'b0;
        end
    end

    assign data_o = out_r;
    assign swap_o = out_swap_r;
    assign v_o    = out_v_r;

endmodule

// File: tb/tb_bsg_swap_halfword_pack.sv
// Directed bench for bsg_swap_halfword_pack: queue-based reference model checked every cycle plus literal spot checks.
module tb_bsg_swap_halfword_pack;
`ifdef BSG_SWAP_HALFWORD_PACK_FLUSH_EN
    localparam bit FLUSH = 1'b1;
`else
    localparam bit FLUSH = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        reset_i = 1'b1;
    logic [15:0] data_i = '0;
    logic        odd_i = 1'b0, last_i = 1'b0, v_i = 1'b0;
    logic        ready_o, swap_o, v_o, yumi_i;
    logic [31:0] data_o;
    logic        auto_yumi = 1'b0, yumi_man = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    // Consumer either takes every word as soon as it appears or follows the manual level.
    assign yumi_i = auto_yumi ? v_o : yumi_man;

    bsg_swap_halfword_pack #(.width_p(32)) dut (
        .clk_i(clk_i), .reset_i(reset_i), .data_i(data_i), .odd_i(odd_i),
        .last_i(last_i), .v_i(v_i), .ready_o(ready_o), .data_o(data_o),
        .swap_o(swap_o), .v_o(v_o), .yumi_i(yumi_i)
    );

    always #5 clk_i = ~clk_i;

    // Reference model: halfwords queue up; every pair becomes a word.
    logic [16:0] hq[$];
    logic        m_v;
    logic [31:0] m_data;
    logic        m_swap;

    always @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            hq.delete();
            m_v    <= 1'b0;
            m_data <= '0;
            m_swap <= 1'b0;
        end else begin : model_step
            automatic logic        m_yumi = auto_yumi ? m_v : yumi_man;
            automatic logic        acc = v_i && (!m_v || m_yumi);
            automatic logic        done = 1'b0;
            automatic logic [31:0] w = '0;
            automatic logic        s = 1'b0;
            if (acc) begin
                if (FLUSH && hq.size() == 0 && last_i) begin
                    done = 1'b1;
                    w    = {16'h0000, data_i};
                    s    = odd_i;
                end else begin
                    hq.push_back({odd_i, data_i});
                    if (hq.size() == 2) begin
                        w    = {hq[1][15:0], hq[0][15:0]};
                        s    = hq[0][16];
                        done = 1'b1;
                        hq.delete();
                    end
                end
            end
            if (done) begin
                m_v    <= 1'b1;
                m_data <= w;
                m_swap <= s;
            end else if (m_yumi) begin
                m_v <= 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk_i) begin
        if (!reset_i) begin
            chk("model v_o", {31'b0, v_o}, {31'b0, m_v});
            chk("model ready_o", {31'b0, ready_o},
                {31'b0, (!m_v || (auto_yumi ? m_v : yumi_man))});
            if (m_v) begin
                chk("model data_o", data_o, m_data);
                chk("model swap_o", {31'b0, swap_o}, {31'b0, m_swap});
            end
            if (yumi_i && !v_o) begin
                miscompares++;
                $display("FAIL protocol: yumi_i asserted while v_o=0 at %0t", $time);
            end
        end
    end

    // Inputs change 1 time unit after the rising edge; the task returns 1 unit after the next edge.
    task automatic step(input logic v, input logic [15:0] d, input logic o, input logic l, input logic y);
        v_i = v; data_i = d; odd_i = o; last_i = l; yumi_man = y;
        @(posedge clk_i); #1;
    endtask

    initial begin
        repeat (2) @(posedge clk_i);
        #1;
        chk("reset ready_o", {31'b0, ready_o}, 32'd1);
        chk("reset v_o", {31'b0, v_o}, 32'd0);
        chk("reset data_o", data_o, 32'h0);
        chk("reset swap_o", {31'b0, swap_o}, 32'd0);
        reset_i = 1'b0;

        // Mid-word reset must discard the held 0x1111.
        step(1, 16'h1111, 0, 0, 0);
        reset_i = 1'b1; #1;
        chk("async reset v_o", {31'b0, v_o}, 32'd0);
        @(posedge clk_i); #1;
        reset_i = 1'b0;
        step(1, 16'hAAAA, 0, 0, 0);
        step(1, 16'hBBBB, 0, 0, 0);
        chk("post-reset pair", data_o, 32'hBBBBAAAA);
        step(0, 16'h0, 0, 0, 1);

        auto_yumi = 1'b1;
        step(1, 16'h5678, 0, 0, 0);
        chk("first half no v_o", {31'b0, v_o}, 32'd0);
        step(1, 16'h1234, 1, 0, 0);
        chk("pair data", data_o, 32'h12345678);
        chk("pair swap", {31'b0, swap_o}, 32'd0);
        chk("pair v_o", {31'b0, v_o}, 32'd1);
        step(0, 16'h0, 0, 0, 0);
        chk("pair v_o one cycle", {31'b0, v_o}, 32'd0);

        step(1, 16'hBEEF, 1, 0, 0);
        step(1, 16'hDEAD, 0, 0, 0);
        chk("odd data", data_o, 32'hDEADBEEF);
        chk("odd swap", {31'b0, swap_o}, 32'd1);
        step(0, 16'h0, 0, 0, 0);

        // Backpressure for 5 cycles, then release with a beat waiting.
        auto_yumi = 1'b0;
        step(1, 16'h0001, 1, 0, 0);
        step(1, 16'h0002, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            chk("stall ready_o", {31'b0, ready_o}, 32'd0);
            step(1, 16'h0003, 0, 0, 0);
            chk("stall data held", data_o, 32'h00020001);
            chk("stall swap held", {31'b0, swap_o}, 32'd1);
        end
        step(1, 16'h0003, 0, 0, 1);
        chk("release v_o", {31'b0, v_o}, 32'd0);
        step(1, 16'h0004, 0, 0, 0);
        chk("release beat taken", data_o, 32'h00040003);
        step(0, 16'h0, 0, 0, 1);

        // Back-to-back stream of 8 halfwords.
        auto_yumi = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk("stream ready_o", {31'b0, ready_o}, 32'd1);
            step(1, 16'hC000 + 16'(i), logic'((i / 2) % 2), 0, 0);
            if (i % 2 == 1)
                chk("stream word", data_o, {16'hC000 + 16'(i), 16'hC000 + 16'(i - 1)});
        end
        step(0, 16'h0, 0, 0, 0);

        // Lone last beat.
        step(1, 16'h00C3, 1, 1, 0);
        if (FLUSH) begin
            chk("flush v_o", {31'b0, v_o}, 32'd1);
            chk("flush data", data_o, 32'h000000C3);
            chk("flush swap", {31'b0, swap_o}, 32'd1);
        end else begin
            chk("no flush v_o", {31'b0, v_o}, 32'd0);
            step(1, 16'h0011, 0, 0, 0);
            chk("no flush pair", data_o, 32'h001100C3);
            chk("no flush swap", {31'b0, swap_o}, 32'd1);
        end
        step(0, 16'h0, 0, 0, 0);
        step(0, 16'h0, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
